lamp_chaser: RTL and testbench
==============================

# lamp_chaser

Sequencer that drives the lamp position code for the 7-lamp display stage. It divides the system clock into a step tick and walks a position code 1..7 in right, left or bounce order. `num` feeds the lamp decoder directly, where 0 means all lamps off and 1..7 selects one lit lamp. The block also emits per-step and per-cycle pulses for effects logic such as sound and seven-segment counters.

## Interface
- `TICK_DIV`, default 12_500_000: clock cycles per step; legal values ≥ 1. The prescaler counter is $clog2(TICK_DIV) bits wide, minimum 1.
- `clk` input 1: system clock. All logic is on the rising edge.
- `rst_n` input 1: reset, synchronous, active-low. One clock; reset is synchronous and active-low.
- `en` input 1: run enable. When 0, the prescaler clears and `num` holds.
- `clr` input 1: synchronous clear. Forces `num` to 0, direction to up, and the prescaler to 0. Ranks below `rst_n` and above all other inputs.
- `mode` input 2: 00 hold, 01 right (ascending), 10 left (descending), 11 bounce.
- `num` output 4: registered position code, 0 or 1..7. Never takes 8..15.
- `dir` output 1: registered current direction. 1 = ascending, 0 = descending.
- `step` output 1: one-cycle pulse, high in the first cycle a new `num` value is visible.
- `wrap` output 1: one-cycle pulse coincident with `step` when a full pass completes.

## Operation
- Reset values (`rst_n`=0 at an edge):
  - `num`=0, `dir`=1, `step`=0, `wrap`=0, prescaler=0.
- Prescaler:
  - While `en`=1 and `clr`=0, it counts 0..TICK_DIV-1 and then returns to 0.
  - The internal tick is asserted when the count equals TICK_DIV-1 and `en`=1.
  - If `en`=0, the prescaler loads 0.
- On tick, the next `num` depends on `mode`:
  - 00 (hold): `num` is unchanged. `step`=0 and `wrap`=0. The tick is consumed.
  - 01 (right): 0→1, then n→n+1; 7→1 with `wrap`=1. `dir` is forced to 1.
  - 10 (left): 0→7, then n→n-1; 1→7 with `wrap`=1. `dir` is forced to 0.
  - 11 (bounce): 0→1 with `dir`=1. Ascending n→n+1; reaching 7 sets `dir`=0. Descending n→n-1; reaching 1 sets `dir`=1 and `wrap`=1. No position repeats at the endpoints: 6,7,6 and 2,1,2.
- `step`=1 on any tick whose mode is not 00. It is asserted even if `num` ends up numerically unchanged, which cannot occur in modes 01, 10 or 11.
- Mode changes mid-run:
  - They take effect at the next tick and start from the current `num`. The prescaler is not disturbed.
  - Entering bounce keeps the current `dir`, except that `num`=7 forces `dir`=0 and `num`=1 forces `dir`=1 before stepping.
- Simultaneous inputs:
  - `clr` and tick in the same cycle: `clr` wins, `step`=0, `wrap`=0.
  - `rst_n`=0 overrides everything.
- `en` deasserted mid-run: `num` and `dir` freeze. Re-enabling restarts a full TICK_DIV period, so no short first step occurs.

## Timing
- `num`, `dir`, `step` and `wrap` are all registered. There are no combinational input-to-output paths.
- Tick at edge k: the new `num`, `step` and `wrap` are visible after edge k. `step` and `wrap` drop after edge k+1.
- First step latency: with the prescaler at 0 and `en` rising before edge 1, the first `num` change appears after edge TICK_DIV.
- Steady state: steps occur every TICK_DIV cycles. With TICK_DIV=1, `num` changes every cycle while enabled and `step` stays high continuously.
- `clr`, `en` and `mode` are sampled at each edge. A one-cycle `clr` pulse is sufficient.

## Test plan
- Reset and right mode: TICK_DIV=4, `rst_n` low for 2 cycles, then `en`=1, `mode`=01.
  - `num` must be 0 until the 4th edge after enable, then step 1,2,…,7,1 every 4 cycles.
  - `wrap`=1 exactly on the 7→1 step, and `step` is one cycle wide each time.
- Left and bounce: TICK_DIV=2.
  - `mode`=10 from `num`=0 must give 7,6,…,1,7 with `wrap` on 1→7.
  - `mode`=11 from 0 must give 1..7,6..1,2, with `dir` toggling after 7 and after 1, and `wrap` only on arrival at 1.
- Hold and enable: in right mode at `num`=4, switch `mode`=00 for 10 ticks.
  - `num` must stay 4 with no `step`.
  - Then drop `en` for 7 cycles and re-raise it. The next step to 5 must arrive exactly TICK_DIV cycles after re-enable.
- Clear collision: assert `clr` on the exact cycle the prescaler reaches TICK_DIV-1.
  - Next cycle: `num`=0, `step`=0, `wrap`=0, `dir`=1.
  - The following step goes to 1 after a full TICK_DIV.
- Mode switch at an endpoint: in right mode at `num`=7, switch to bounce. The next `num` must be 6 with `dir`=0.
- Reset mid-run: pull `rst_n` low for one cycle while `num`=5 and the prescaler is mid-count.
  - All outputs must return to reset values on that edge.
  - Recovery follows the first-step latency rule.

Source files
------------

// File: rtl/lamp_chaser_if.sv
// lamp_chaser_if
//   Groups the control inputs and lamp outputs of the lamp chaser.
//   master : drives en/clr/mode, observes num/dir/step/wrap (effects/test side)
//   slave  : the chaser itself
//   Signals:
//     en   - run enable
//     clr  - synchronous clear (num->0, dir->ascending, prescaler->0)
//     mode - 00 hold, 01 right, 10 left, 11 bounce
//     num  - registered lamp position code, 0 (all off) or 1..7
//     dir  - registered direction, 1 = ascending
//     step - one-cycle pulse when a new num becomes visible
//     wrap - one-cycle pulse with step when a full pass completes
interface lamp_chaser_if;
  logic       en;
  logic       clr;
  logic [1:0] mode;
  logic [3:0] num;
  logic       dir;
  logic       step;
  logic       wrap;

  modport master (
    output en, clr, mode,
    input  num, dir, step, wrap
  );

  modport slave (
    input  en, clr, mode,
    output num, dir, step, wrap
  );
endinterface

// File: rtl/lamp_chaser.sv
// lamp_chaser
//   Divides clk into a step tick (one tick every TICK_DIV cycles while
//   enabled) and walks a lamp position code 1..7 in right, left or bounce
//   order. Emits step/wrap pulses for downstream effects logic.
//   Ports:
//     clk   - system clock, rising edge
//     rst_n - synchronous active-low reset
//     bus   - lamp_chaser_if.slave (en, clr, mode in; num, dir, step, wrap out)
//   Parameter:
//     TICK_DIV - clock cycles per step, >= 1
module lamp_chaser #(
  parameter int TICK_DIV = 12_500_000
) (
  input  logic          clk,
  input  logic          rst_n,
  lamp_chaser_if.slave  bus
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

  localparam logic [1:0] MODE_HOLD   = 2'b00;
  localparam logic [1:0] MODE_RIGHT  = 2'b01;
  localparam logic [1:0] MODE_LEFT   = 2'b10;
  localparam logic [1:0] MODE_BOUNCE = 2'b11;

  localparam logic [3:0] POS_OFF   = 4'd0;
  localparam logic [3:0] POS_FIRST = 4'd1;
  localparam logic [3:0] POS_LAST  = 4'd7;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       num_q, num_d;
  logic             dir_q, dir_d;
  logic             step_q, step_d;
  logic             wrap_q, wrap_d;

  logic             tick;
  logic             bounce_up;

  // Tick fires on the last prescaler count; en gating means a re-enable
  // always starts a full period because en=0 also parks the counter at 0.
  assign tick = bus.en && (cnt_q == CNT_MAX);

  always_comb begin
    cnt_d = cnt_q;
    if (bus.clr || !bus.en) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Effective bounce direction: the endpoints override the stored dir so
  // that entering bounce at 7 or 1 never tries to step off the end.
  always_comb begin
    bounce_up = dir_q;
    if (num_q == POS_LAST) begin
      bounce_up = 1'b0;
    end else if (num_q == POS_FIRST) begin
      bounce_up = 1'b1;
    end
  end

  always_comb begin
    num_d  = num_q;
    dir_d  = dir_q;
    step_d = 1'b0;
    wrap_d = 1'b0;

    if (bus.clr) begin
      // Clear outranks a coincident tick: no step/wrap pulse.
      num_d = POS_OFF;
      dir_d = 1'b1;
    end else if (tick) begin
      unique case (bus.mode)
        MODE_HOLD: begin
          // Tick is consumed with no visible change.
        end
        MODE_RIGHT: begin
          step_d = 1'b1;
          dir_d  = 1'b1;
          if (num_q == POS_LAST) begin
            num_d  = POS_FIRST;
            wrap_d = 1'b1;
          end else begin
            num_d = num_q + 4'd1;
          end
        end
        MODE_LEFT: begin
          step_d = 1'b1;
          dir_d  = 1'b0;
          if (num_q == POS_OFF) begin
            num_d = POS_LAST;
          end else if (num_q == POS_FIRST) begin
            num_d  = POS_LAST;
            wrap_d = 1'b1;
          end else begin
            num_d = num_q - 4'd1;
          end
        end
        MODE_BOUNCE: begin
          step_d = 1'b1;
          if (num_q == POS_OFF) begin
            num_d = POS_FIRST;
            dir_d = 1'b1;
          end else if (bounce_up) begin
            num_d = num_q + 4'd1;
            // Turn around on arrival so 7 is shown only once.
            dir_d = (num_q + 4'd1 != POS_LAST);
          end else begin
            num_d = num_q - 4'd1;
            if (num_q - 4'd1 == POS_FIRST) begin
              dir_d  = 1'b1;
              wrap_d = 1'b1;
            end else begin
              dir_d = 1'b0;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      num_q  <= POS_OFF;
      dir_q  <= 1'b1;
      step_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      num_q  <= num_d;
      dir_q  <= dir_d;
      step_q <= step_d;
      wrap_q <= wrap_d;
    end
  end

  assign bus.num  = num_q;
  assign bus.dir  = dir_q;
  assign bus.step = step_q;
  assign bus.wrap = wrap_q;

endmodule

// File: tb/tb_lamp_chaser.sv
// tb_lamp_chaser
//   Directed bench for lamp_chaser. Three instances share clk/rst_n:
//     dut_a TICK_DIV=4 (right, hold, enable, clear, endpoint, mid-run reset)
//     dut_b TICK_DIV=2 (left and bounce sequences)
//     dut_c TICK_DIV=1 (step every cycle)
//   Observed state is packed as {num[3:0], dir, step, wrap}.
module tb_lamp_chaser;

  logic clk;
  logic rst_n;

  int checks;
  int failures;

  lamp_chaser_if bus_a ();
  lamp_chaser_if bus_b ();
  lamp_chaser_if bus_c ();

  lamp_chaser #(.TICK_DIV(4)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  lamp_chaser #(.TICK_DIV(2)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));
  lamp_chaser #(.TICK_DIV(1)) dut_c (.clk(clk), .rst_n(rst_n), .bus(bus_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: sim time expired before summary, required completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [6:0] pack(input int n, input bit d, input bit s, input bit w);
    pack = {4'(n), d, s, w};
  endfunction

  // Advance one clock; sample and drive 1 time unit after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [6:0] got;
    rst_n = 1'b0;
    bus_a.en = 1'b0; bus_a.clr = 1'b0; bus_a.mode = 2'b00;
    bus_b.en = 1'b0; bus_b.clr = 1'b0; bus_b.mode = 2'b00;
    bus_c.en = 1'b0; bus_c.clr = 1'b0; bus_c.mode = 2'b00;
    cyc();
    cyc();
    got = {bus_a.num, bus_a.dir, bus_a.step, bus_a.wrap};
    checks++;
    if (got !== pack(0, 1, 0, 0)) begin
      failures++;
      $display("FAIL reset_a: got %b required %b", got, pack(0, 1, 0, 0));
    end
    got = {bus_b.num, bus_b.dir, bus_b.step, bus_b.wrap};
    checks++;
    if (got !== pack(0, 1, 0, 0)) begin
      failures++;
      $display("FAIL reset_b: got %b required %b", got, pack(0, 1, 0, 0));
    end
    rst_n = 1'b1;
    $display("reset: a num=%0d dir=%b", bus_a.num, bus_a.dir);
  endtask

  task automatic test_tick1();
    logic [6:0] got;
    logic [6:0] exp;
    bus_c.en = 1'b1;
    bus_c.mode = 2'b01;
    for (int k = 1; k <= 9; k++) begin
      cyc();
      got = {bus_c.num, bus_c.dir, bus_c.step, bus_c.wrap};
      exp = pack(((k - 1) % 7) + 1, 1, 1, k == 8);
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL tick1_cycle%0d: got %b required %b", k, got, exp);
      end
    end
    bus_c.en = 1'b0;
    cyc();
    got = {bus_c.num, bus_c.dir, bus_c.step, bus_c.wrap};
    checks++;
    if (got !== pack(2, 1, 0, 0)) begin
      failures++;
      $display("FAIL tick1_disable: got %b required %b", got, pack(2, 1, 0, 0));
    end
    $display("tick1: continuous steps checked, num=%0d", bus_c.num);
  endtask

  task automatic test_left_bounce();
    logic [6:0] got;
    logic [6:0] exp;
    int prev;
    int lseq[8];
    int bseq[14];
    bit bdir[14];
    lseq = '{7, 6, 5, 4, 3, 2, 1, 7};
    bseq = '{1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 2};
    bdir = '{1, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 1, 1};
    bus_b.en = 1'b1;
    bus_b.mode = 2'b10;
    prev = 0;
    for (int s = 0; s < 8; s++) begin
      cyc();
      got = {bus_b.num, bus_b.dir, bus_b.step, bus_b.wrap};
      exp = pack(prev, (s == 0) ? 1'b1 : 1'b0, 0, 0);
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL left_gap%0d: got %b required %b", s, got, exp);
      end
      cyc();
      got = {bus_b.num, bus_b.dir, bus_b.step, bus_b.wrap};
      exp = pack(lseq[s], 0, 1, s == 7);
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL left_step%0d: got %b required %b", s, got, exp);
      end
      prev = lseq[s];
      $display("left step %0d: num=%0d wrap=%b", s, bus_b.num, bus_b.wrap);
    end
    bus_b.clr = 1'b1;
    cyc();
    bus_b.clr = 1'b0;
    bus_b.mode = 2'b11;
    for (int s = 0; s < 14; s++) begin
      cyc();
      cyc();
      got = {bus_b.num, bus_b.dir, bus_b.step, bus_b.wrap};
      exp = pack(bseq[s], bdir[s], 1, s == 12);
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL bounce_step%0d: got %b required %b", s, got, exp);
      end
      $display("bounce step %0d: num=%0d dir=%b wrap=%b", s, bus_b.num, bus_b.dir, bus_b.wrap);
    end
    bus_b.en = 1'b0;
  endtask

  // Right mode from num=0: 1..7,1,2,3,4 with a step every 4 cycles.
  task automatic test_right();
    logic [6:0] got;
    logic [6:0] exp;
    int prev;
    int seq[11];
    seq = '{1, 2, 3, 4, 5, 6, 7, 1, 2, 3, 4};
    bus_a.en = 1'b1;
    bus_a.mode = 2'b01;
    prev = 0;
    for (int s = 0; s < 11; s++) begin
      for (int k = 1; k <= 4; k++) begin
        cyc();
        got = {bus_a.num, bus_a.dir, bus_a.step, bus_a.wrap};
        if (k < 4) exp = pack(prev, 1, 0, 0);
        else       exp = pack(seq[s], 1, 1, s == 7);
        checks++;
        if (got !== exp) begin
          failures++;
          $display("FAIL right_step%0d_cyc%0d: got %b required %b", s, k, got, exp);
        end
      end
      prev = seq[s];
      $display("right step %0d: num=%0d wrap=%b", s, bus_a.num, bus_a.wrap);
    end
  endtask

  task automatic test_hold_enable();
    logic [6:0] got;
    logic [6:0] exp;
    bus_a.mode = 2'b00;
    for (int k = 1; k <= 40; k++) begin
      cyc();
      got = {bus_a.num, bus_a.dir, bus_a.step, bus_a.wrap};
      checks++;
      if (got !== pack(4, 1, 0, 0)) begin
        failures++;
        $display("FAIL hold_cyc%0d: got %b required %b", k, got, pack(4, 1, 0, 0));
      end
    end
    bus_a.mode = 2'b01;
    bus_a.en = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      cyc();
      got = {bus_a.num, bus_a.dir, bus_a.step, bus_a.wrap};
      checks++;
      if (got !== pack(4, 1, 0, 0)) begin
        failures++;
        $display("FAIL disabled_cyc%0d: got %b required %b", k, got, pack(4, 1, 0, 0));
      end
    end
    bus_a.en = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      cyc();
      got = {bus_a.num, bus_a.dir, bus_a.step, bus_a.wrap};
      exp = (k < 4) ? pack(4, 1, 0, 0) : pack(5, 1, 1, 0);
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL reenable_cyc%0d: got %b required %b", k, got, exp);
      end
    end
    $display("hold/enable: num=%0d after re-enable", bus_a.num);
  endtask

  task automatic test_clear_collision();
    logic [6:0] got;
    logic [6:0] exp;
    bus_a.mode = 2'b10;
    for (int k = 1; k <= 4; k++) cyc();
    got = {bus_a.num, bus_a.dir, bus_a.step, bus_a.wrap};
    checks++;
    if (got !== pack(4, 0, 1, 0)) begin
      failures++;
      $display("FAIL left_before_clr: got %b required %b", got, pack(4, 0, 1, 0));
    end
    // Three more edges put the prescaler at TICK_DIV-1.
    for (int k = 1; k <= 3; k++) cyc();
    bus_a.clr = 1'b1;
    cyc();
    bus_a.clr = 1'b0;
    bus_a.mode = 2'b01;
    got = {bus_a.num, bus_a.dir, bus_a.step, bus_a.wrap};
    checks++;
    if (got !== pack(0, 1, 0, 0)) begin
      failures++;
      $display("FAIL clr_collision: got %b required %b", got, pack(0, 1, 0, 0));
    end
    for (int k = 1; k <= 4; k++) begin
      cyc();
      got = {bus_a.num, bus_a.dir, bus_a.step, bus_a.wrap};
      exp = (k < 4) ? pack(0, 1, 0, 0) : pack(1, 1, 1, 0);
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL clr_recover_cyc%0d: got %b required %b", k, got, exp);
      end
    end
    $display("clear collision: num=%0d after recovery", bus_a.num);
  endtask

  task automatic test_endpoint_switch();
    logic [6:0] got;
    logic [6:0] exp;
    for (int s = 2; s <= 7; s++) begin
      for (int k = 1; k <= 4; k++) cyc();
      got = {bus_a.num, bus_a.dir, bus_a.step, bus_a.wrap};
      exp = pack(s, 1, 1, 0);
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL endpoint_climb%0d: got %b required %b", s, got, exp);
      end
    end
    bus_a.mode = 2'b11;
    for (int k = 1; k <= 4; k++) cyc();
    got = {bus_a.num, bus_a.dir, bus_a.step, bus_a.wrap};
    checks++;
    if (got !== pack(6, 0, 1, 0)) begin
      failures++;
      $display("FAIL endpoint_bounce: got %b required %b", got, pack(6, 0, 1, 0));
    end
    $display("endpoint switch: num=%0d dir=%b", bus_a.num, bus_a.dir);
  endtask

  task automatic test_reset_midrun();
    logic [6:0] got;
    logic [6:0] exp;
    for (int k = 1; k <= 4; k++) cyc();
    got = {bus_a.num, bus_a.dir, bus_a.step, bus_a.wrap};
    checks++;
    if (got !== pack(5, 0, 1, 0)) begin
      failures++;
      $display("FAIL before_midrun_reset: got %b required %b", got, pack(5, 0, 1, 0));
    end
    cyc();
    cyc();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    got = {bus_a.num, bus_a.dir, bus_a.step, bus_a.wrap};
    checks++;
    if (got !== pack(0, 1, 0, 0)) begin
      failures++;
      $display("FAIL midrun_reset: got %b required %b", got, pack(0, 1, 0, 0));
    end
    for (int k = 1; k <= 4; k++) begin
      cyc();
      got = {bus_a.num, bus_a.dir, bus_a.step, bus_a.wrap};
      exp = (k < 4) ? pack(0, 1, 0, 0) : pack(1, 1, 1, 0);
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL reset_recover_cyc%0d: got %b required %b", k, got, exp);
      end
    end
    $display("midrun reset: num=%0d after recovery", bus_a.num);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_tick1();
    test_left_bounce();
    test_right();
    test_hold_enable();
    test_clear_collision();
    test_endpoint_switch();
    test_reset_midrun();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
